conv_sequencer: RTL and testbench

//   Controller that sequences one conv pass: pops 9 weights then 9 biases from a parameter FIFO into

---
 rtl/conv_sequencer.sv | 177 +++++++++++++++++
 tb/tb_conv_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// Sequences one conv pass: loads weights then biases, streams an image's pixels
// gated by conv idle, forwards results to the output FIFO and pulses done.
module conv_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 32,
    parameter int NUM_WEIGHTS  = 9,
    parameter int NUM_BIASES   = 9,
    parameter int IMG_DIM      = 224
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow_err,
    input  logic                    param_empty,
    output logic                    param_rd_en,
    input  logic [DATA_WIDTH-1:0]   param_dout,
    input  logic                    pix_empty,
    output logic                    pix_rd_en,
    input  logic [DATA_WIDTH-1:0]   pix_dout,
    input  logic                    out_full,
    output logic                    out_wr_en,
    output logic [RESULT_WIDTH-1:0] out_din,
    output logic                    conv_weights_valid,
    output logic                    conv_bias_valid,
    output logic [DATA_WIDTH-1:0]   conv_new_pixel,
    output logic                    conv_new_data_valid,
    output logic                    conv_out_accepting,
    input  logic                    conv_idle,
    input  logic [RESULT_WIDTH-1:0] conv_result,
    input  logic                    conv_result_valid,
    input  logic                    conv_image_done,
    output logic [31:0]             result_count
);

    localparam int NUM_PIXELS = IMG_DIM * IMG_DIM;
    localparam int SENT_W     = $clog2(NUM_PIXELS + 1);
    localparam int LCNT_W     = $clog2(((NUM_WEIGHTS > NUM_BIASES) ? NUM_WEIGHTS : NUM_BIASES) + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]            r_state;
    logic [LCNT_W-1:0]     r_load_cnt;
    logic [SENT_W-1:0]     r_sent;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_overflow;
    logic                  r_weights_valid;
    logic                  r_bias_valid;
    logic                  r_new_data_valid;
    logic [DATA_WIDTH-1:0] r_new_pixel;
    logic [31:0]           r_result_count;

    logic w_param_pop;
    logic w_pix_pop;
    logic w_collect;
    logic w_wr;

    // The !r_new_data_valid term spaces pixels two cycles apart, covering conv's idle deassert lag.
    assign w_param_pop = ((r_state == S_LOAD_W) || (r_state == S_LOAD_B)) && !param_empty;
    assign w_pix_pop   = (r_state == S_STREAM) && !pix_empty && conv_idle && !r_new_data_valid
                         && (r_sent < SENT_W'(NUM_PIXELS));
    assign w_collect   = (r_state == S_STREAM) || (r_state == S_DRAIN);
    assign w_wr        = w_collect && conv_result_valid && !out_full;

    assign param_rd_en         = w_param_pop;
    assign pix_rd_en           = w_pix_pop;
    assign out_wr_en           = w_wr;
    assign out_din             = conv_result;
    assign conv_out_accepting  = !out_full;
    assign busy                = r_busy;
    assign done                = r_done;
    assign overflow_err        = r_overflow;
    assign conv_weights_valid  = r_weights_valid;
    assign conv_bias_valid     = r_bias_valid;
    assign conv_new_data_valid = r_new_data_valid;
    assign conv_new_pixel      = r_new_pixel;
    assign result_count        = r_result_count;

    // Pass sequencing FSM with registered conv strobes and result bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_load_cnt       <= '0;
            r_sent           <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_overflow       <= 1'b0;
            r_weights_valid  <= 1'b0;
            r_bias_valid     <= 1'b0;
            r_new_data_valid <= 1'b0;
            r_new_pixel      <= '0;
            r_result_count   <= 32'd0;
        end else begin
            r_done           <= 1'b0;
            r_weights_valid  <= 1'b0;
            r_bias_valid     <= 1'b0;
            r_new_data_valid <= 1'b0;
            if (w_wr) begin
                r_result_count <= r_result_count + 32'd1;
            end
            if (w_collect && conv_result_valid && out_full) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state        <= S_LOAD_W;
                        r_busy         <= 1'b1;
                        r_result_count <= 32'd0;
                        r_load_cnt     <= '0;
                        r_sent         <= '0;
                    end
                end
                S_LOAD_W: begin
                    if (w_param_pop) begin
                        r_new_pixel     <= param_dout;
                        r_weights_valid <= 1'b1;
                        if (r_load_cnt == LCNT_W'(NUM_WEIGHTS - 1)) begin
                            r_load_cnt <= '0;
                            r_state    <= S_LOAD_B;
                        end else begin
                            r_load_cnt <= r_load_cnt + LCNT_W'(1);
                        end
                    end
                end
                S_LOAD_B: begin
                    if (w_param_pop) begin
                        r_new_pixel  <= param_dout;
                        r_bias_valid <= 1'b1;
                        if (r_load_cnt == LCNT_W'(NUM_BIASES - 1)) begin
                            r_load_cnt <= '0;
                            r_state    <= S_STREAM;
                        end else begin
                            r_load_cnt <= r_load_cnt + LCNT_W'(1);
                        end
                    end
                end
                S_STREAM: begin
                    if (w_pix_pop) begin
                        r_new_pixel      <= pix_dout;
                        r_new_data_valid <= 1'b1;
                        r_sent           <= r_sent + SENT_W'(1);
                    end
                    if (conv_image_done) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_pix_pop && (r_sent == SENT_W'(NUM_PIXELS - 1))) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (conv_image_done) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Randomized bench for conv_sequencer: FIFO, conv-idle and result models drive the
// DUT while a pass-level reference model checks every strobe, count and flag.
module tb_conv_sequencer;

    localparam int DW    = 8;
    localparam int RW    = 32;
    localparam int NW    = 9;
    localparam int NB    = 9;
    localparam int DIM   = 16;
    localparam int NPIX  = DIM * DIM;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done, overflow_err;
    logic          param_empty, param_rd_en;
    logic [DW-1:0] param_dout;
    logic          pix_empty, pix_rd_en;
    logic [DW-1:0] pix_dout;
    logic          out_full, out_wr_en;
    logic [RW-1:0] out_din;
    logic          conv_weights_valid, conv_bias_valid, conv_new_data_valid, conv_out_accepting;
    logic [DW-1:0] conv_new_pixel;
    logic          conv_idle;
    logic [RW-1:0] conv_result;
    logic          conv_result_valid, conv_image_done;
    logic [31:0]   result_count;

    conv_sequencer #(
        .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .NUM_WEIGHTS(NW), .NUM_BIASES(NB), .IMG_DIM(DIM)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .overflow_err(overflow_err),
        .param_empty(param_empty), .param_rd_en(param_rd_en), .param_dout(param_dout),
        .pix_empty(pix_empty), .pix_rd_en(pix_rd_en), .pix_dout(pix_dout),
        .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din),
        .conv_weights_valid(conv_weights_valid), .conv_bias_valid(conv_bias_valid),
        .conv_new_pixel(conv_new_pixel), .conv_new_data_valid(conv_new_data_valid),
        .conv_out_accepting(conv_out_accepting), .conv_idle(conv_idle),
        .conv_result(conv_result), .conv_result_valid(conv_result_valid),
        .conv_image_done(conv_image_done), .result_count(result_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] q_param[$];
    logic [DW-1:0] q_pix[$];
    logic [DW-1:0] exp_w[$];
    logic [DW-1:0] exp_b[$];
    logic [DW-1:0] exp_pix[$];

    int  n_w, n_b, n_pix, n_popped, n_done, idle_hold;
    int  model_rc;
    bit  model_ovf, model_idle, idle_next, busy_exp, phase_collect, prev_ndv;
    bit  toggle_mode, toggle_bit, force_full, force_rv;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        toggle_bit  = ~toggle_bit;
        param_empty = (q_param.size() == 0) ||
                      (toggle_mode ? toggle_bit : ($urandom_range(0, 3) == 0));
        param_dout  = (q_param.size() != 0) ? q_param[0] : 8'h00;
        pix_empty   = (q_pix.size() == 0) || ($urandom_range(0, 3) == 0);
        pix_dout    = (q_pix.size() != 0) ? q_pix[0] : 8'h00;
        out_full    = force_full || ($urandom_range(0, 9) == 0);
        conv_result_valid = force_rv || ($urandom_range(0, 2) == 0);
        conv_result = $urandom;
    endtask

    task automatic model_reset();
        n_w = 0; n_b = 0; n_pix = 0; n_popped = 0; idle_hold = 0;
        model_rc = 0; model_ovf = 1'b0; model_idle = 1'b1; idle_next = 1'b0;
        busy_exp = 1'b0; phase_collect = 1'b0; prev_ndv = 1'b0;
        q_param.delete(); q_pix.delete();
        conv_idle = 1'b1;
    endtask

    // One clock cycle: combinational checks before the edge, registered checks after it.
    task automatic tick();
        logic p_pop, x_pop, wr_exp, done_req, start_acc;
        @(negedge clock);
        p_pop     = param_rd_en;
        x_pop     = pix_rd_en;
        start_acc = start && model_idle;
        done_req  = conv_image_done && phase_collect;
        wr_exp    = phase_collect && conv_result_valid && !out_full;
        if (p_pop) check_eq("param_pop_while_empty", param_empty, 1'b0);
        if (x_pop) begin
            check_eq("pix_pop_while_busy_conv", conv_idle, 1'b1);
            check_eq("pix_pop_back_to_back", conv_new_data_valid, 1'b0);
            check_eq("pix_pop_while_empty", pix_empty, 1'b0);
            check_eq("pix_pop_excess", (n_popped < NPIX), 1'b1);
            n_popped++;
        end
        check_eq("out_wr_en", out_wr_en, wr_exp);
        if (wr_exp) begin
            check_eq("out_din", out_din, conv_result);
            model_rc++;
        end
        if (phase_collect && conv_result_valid && out_full) model_ovf = 1'b1;
        check_eq("out_accepting", conv_out_accepting, !out_full);

        @(posedge clock);
        #1;
        if (p_pop) void'(q_param.pop_front());
        if (x_pop) void'(q_pix.pop_front());
        if (idle_next) begin
            model_idle = 1'b1;
            idle_next  = 1'b0;
        end
        if (start_acc) begin
            busy_exp = 1'b1; model_idle = 1'b0; model_rc = 0;
            n_w = 0; n_b = 0; n_pix = 0; n_popped = 0;
        end
        if (done_req) begin
            busy_exp = 1'b0; phase_collect = 1'b0; idle_next = 1'b1; n_done++;
        end
        check_eq("done", done, done_req);
        check_eq("busy", busy, busy_exp);
        check_eq("weight_bias_overlap", conv_weights_valid & conv_bias_valid, 1'b0);
        if (conv_weights_valid) begin
            check_eq("weight_after_bias", n_b, 0);
            check_eq("weight_value", conv_new_pixel, (n_w < exp_w.size()) ? exp_w[n_w] : 8'hxx);
            n_w++;
        end
        if (conv_bias_valid) begin
            check_eq("bias_before_weights_done", n_w, NW);
            check_eq("bias_value", conv_new_pixel, (n_b < exp_b.size()) ? exp_b[n_b] : 8'hxx);
            n_b++;
            if (n_b == NB) phase_collect = 1'b1;
        end
        if (conv_new_data_valid) begin
            check_eq("pixel_gap", prev_ndv, 1'b0);
            check_eq("pixel_value", conv_new_pixel,
                     (n_pix < exp_pix.size()) ? exp_pix[n_pix] : 8'hxx);
            n_pix++;
        end
        prev_ndv = conv_new_data_valid;
        check_eq("result_count", result_count, model_rc);
        check_eq("overflow_err", overflow_err, model_ovf);
        // Conv lowers idle one cycle after it sees data, then stays busy for two cycles.
        conv_idle = (idle_hold == 0);
        if (conv_new_data_valid) idle_hold = 2;
        else if (idle_hold > 0) idle_hold--;
        drive_inputs();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_ovf"}, overflow_err, 1'b0);
        check_eq({tag, "_param_rd"}, param_rd_en, 1'b0);
        check_eq({tag, "_pix_rd"}, pix_rd_en, 1'b0);
        check_eq({tag, "_out_wr"}, out_wr_en, 1'b0);
        check_eq({tag, "_valids"}, {conv_weights_valid, conv_bias_valid, conv_new_data_valid}, 3'b000);
        check_eq({tag, "_pixel"}, conv_new_pixel, 8'h00);
        check_eq({tag, "_rc"}, result_count, 32'd0);
    endtask

    task automatic run_pass(input bit fixed_params, input bit toggle, input bit burst, input bit do_reset);
        logic [DW-1:0] fixed_w[NW] = '{8'h01, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFE, 8'hFF};
        logic [DW-1:0] v;
        int d0;
        bit burst_done = 1'b0;
        exp_w.delete(); exp_b.delete(); exp_pix.delete();
        for (int i = 0; i < NW; i++) begin
            v = fixed_params ? fixed_w[i] : DW'($urandom);
            exp_w.push_back(v); q_param.push_back(v);
        end
        for (int i = 0; i < NB; i++) begin
            v = fixed_params ? 8'h00 : DW'($urandom);
            exp_b.push_back(v); q_param.push_back(v);
        end
        for (int i = 0; i < NPIX; i++) begin
            v = DW'($urandom);
            exp_pix.push_back(v); q_pix.push_back(v);
        end
        toggle_mode = toggle;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 400 && n_b < NB; c++) tick();
        check_eq("weights_loaded", n_w, NW);
        check_eq("biases_loaded", n_b, NB);
        for (int c = 0; c < NPIX * 10 && n_pix < NPIX; c++) begin
            if (burst && !burst_done && n_pix == NPIX / 2) begin
                force_full = 1'b1; force_rv = 1'b1;
                repeat (100) tick();
                force_full = 1'b0; force_rv = 1'b0;
                burst_done = 1'b1;
                check_eq("overflow_after_full", overflow_err, 1'b1);
            end
            if (do_reset && n_pix == NPIX / 3) begin
                #2;
                reset = 1'b1;
                #1;
                check_all_zero("mid_reset");
                model_reset();
                @(posedge clock);
                #1;
                reset = 1'b0;
                drive_inputs();
                return;
            end
            start = (n_pix == 5);
            tick();
        end
        start = 1'b0;
        check_eq("pixels_issued", n_pix, NPIX);
        repeat (6) tick();
        check_eq("pixels_popped", n_popped, NPIX);
        check_eq("pixels_after_drain", n_pix, NPIX);
        d0 = n_done;
        conv_image_done = 1'b1;
        tick();
        conv_image_done = 1'b0;
        repeat (3) tick();
        check_eq("done_pulses", n_done, d0 + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; conv_image_done = 1'b0;
        force_full = 1'b0; force_rv = 1'b0; toggle_mode = 1'b0; toggle_bit = 1'b0;
        n_done = 0;
        model_reset();
        drive_inputs();
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        repeat (3) tick();
        run_pass(1'b1, 1'b1, 1'b0, 1'b0);
        run_pass(1'b0, 1'b0, 1'b1, 1'b0);
        run_pass(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        run_pass(1'b0, 1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
